// File: rtl/humanlike_stopwatch.sv
// Stopwatch with h:m:s.ms fields, up/down counting, load/clear/lap and expiry on down-count to zero.
// A millisecond prescaler derived from CLK_HZ paces the time updates.
module humanlike_stopwatch #(
  parameter int unsigned CLK_HZ    = 50000000,
  parameter int unsigned HOURS_MOD = 24
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        dir,
  input  logic        load,
  input  logic [26:0] load_time,
  input  logic        lap,
  output logic [26:0] cur_time,
  output logic [26:0] lap_time,
  output logic        running,
  output logic        ms_tick,
  output logic        sec_tick,
  output logic        zero,
  output logic        load_err
);

  localparam int unsigned DIV = CLK_HZ / 1000;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
  localparam logic [4:0]    H_MAX   = 5'(HOURS_MOD - 1);
  localparam logic [5:0]    H_LIM   = 6'(HOURS_MOD);

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    RUNNING = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [26:0]   time_q, time_d, lap_q, lap_d;
  logic [26:0]   step_time;
  logic          step_wrap;
  logic          ms_d, sec_d, zero_d, err_d;
  logic          load_ok, time_is_zero;

  logic [4:0] h,  lh,  n_h;
  logic [5:0] m,  lm,  n_m;
  logic [5:0] s,  ls,  n_s;
  logic [9:0] ms, lms, n_ms;

  assign {h, m, s, ms}     = time_q;
  assign {lh, lm, ls, lms} = load_time;
  assign load_ok      = ({1'b0, lh} < H_LIM) && (lm <= 6'd59) && (ls <= 6'd59) && (lms <= 10'd999);
  assign time_is_zero = (time_q == '0);

  // One-millisecond step in the current direction with field carries/borrows.
  // The down path is only used when time is non-zero, so hours never underflow.
  always_comb begin
    n_h       = h;
    n_m       = m;
    n_s       = s;
    n_ms      = ms;
    step_wrap = 1'b0;
    if (!dir) begin
      if (ms == 10'd999) begin
        n_ms      = '0;
        step_wrap = 1'b1;
        if (s == 6'd59) begin
          n_s = '0;
          if (m == 6'd59) begin
            n_m = '0;
            n_h = (h == H_MAX) ? '0 : h + 5'd1;
          end else begin
            n_m = m + 6'd1;
          end
        end else begin
          n_s = s + 6'd1;
        end
      end else begin
        n_ms = ms + 10'd1;
      end
    end else begin
      if (ms == 10'd0) begin
        n_ms      = 10'd999;
        step_wrap = 1'b1;
        if (s == 6'd0) begin
          n_s = 6'd59;
          if (m == 6'd0) begin
            n_m = 6'd59;
            n_h = h - 5'd1;
          end else begin
            n_m = m - 6'd1;
          end
        end else begin
          n_s = s - 6'd1;
        end
      end else begin
        n_ms = ms - 10'd1;
      end
    end
    step_time = {n_h, n_m, n_s, n_ms};
  end

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    time_d  = time_q;
    lap_d   = lap ? time_q : lap_q;
    ms_d    = 1'b0;
    sec_d   = 1'b0;
    zero_d  = 1'b0;
    err_d   = 1'b0;
    if (clear) begin
      time_d = '0;
      pre_d  = '0;
      if (state_q == EXPIRED) state_d = STOPPED;
    end else if (load && load_ok) begin
      time_d = load_time;
      pre_d  = '0;
      if (state_q == EXPIRED) state_d = STOPPED;
    end else begin
      // A rejected load still outranks stop/start but does not pause counting.
      err_d = load;
      case (state_q)
        STOPPED: begin
          if (!load && !stop && start && !(dir && time_is_zero)) state_d = RUNNING;
        end
        RUNNING: begin
          if (!load && stop) begin
            state_d = STOPPED;
          end else if (pre_q == PRE_MAX) begin
            pre_d = '0;
            if (dir && time_is_zero) begin
              zero_d  = 1'b1;
              state_d = EXPIRED;
            end else begin
              time_d = step_time;
              ms_d   = 1'b1;
              sec_d  = step_wrap;
              if (dir && (step_time == '0)) begin
                zero_d  = 1'b1;
                state_d = EXPIRED;
              end
            end
          end else begin
            pre_d = pre_q + PW'(1);
          end
        end
        EXPIRED: ;
        default: state_d = STOPPED;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= STOPPED;
      pre_q    <= '0;
      time_q   <= '0;
      lap_q    <= '0;
      running  <= 1'b0;
      ms_tick  <= 1'b0;
      sec_tick <= 1'b0;
      zero     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      time_q   <= time_d;
      lap_q    <= lap_d;
      running  <= (state_d == RUNNING);
      ms_tick  <= ms_d;
      sec_tick <= sec_d;
      zero     <= zero_d;
      load_err <= err_d;
    end
  end

  assign cur_time = time_q;
  assign lap_time = lap_q;

endmodule

// File: tb/tb_humanlike_stopwatch.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// random stimulus against a total-milliseconds reference model.
module tb_humanlike_stopwatch;

  localparam int unsigned CLK_HZ = 4000;
  localparam int          DIV    = 4;
  localparam int          HM     = 24;
  localparam int          FULL   = HM * 3600000;

  logic        clock = 1'b0;
  logic        reset;
  logic        start, stop, clear, dir, load, lap;
  logic [26:0] load_time;
  logic [26:0] cur_time, lap_time;
  logic        running, ms_tick, sec_tick, zero, load_err;

  humanlike_stopwatch #(.CLK_HZ(CLK_HZ), .HOURS_MOD(HM)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .dir(dir), .load(load), .load_time(load_time), .lap(lap),
    .cur_time(cur_time), .lap_time(lap_time), .running(running),
    .ms_tick(ms_tick), .sec_tick(sec_tick), .zero(zero), .load_err(load_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: time as a plain millisecond count, mode 0=stopped 1=running 2=expired.
  int   m_mode, m_pre, m_total, m_lap;
  logic e_ms, e_sec, e_zero, e_err;

  typedef struct {
    logic        st, sp, cl, dr, ld;
    logic [26:0] lt, et;
    logic        er, ems, esec, ez, eerr;
  } vec_t;

  localparam int NV = 16;
  vec_t vt [NV];

  function automatic logic [26:0] pk(int hh, int mm, int ss, int mss);
    return {5'(hh), 6'(mm), 6'(ss), 10'(mss)};
  endfunction

  function automatic int to_ms(logic [26:0] t);
    return int'(t[26:22]) * 3600000 + int'(t[21:16]) * 60000 + int'(t[15:10]) * 1000 + int'(t[9:0]);
  endfunction

  function automatic logic [26:0] from_ms(int v);
    return pk(v / 3600000, (v / 60000) % 60, (v / 1000) % 60, v % 1000);
  endfunction

  function automatic logic fields_ok(logic [26:0] t);
    return (int'(t[26:22]) < HM) && (int'(t[21:16]) < 60) && (int'(t[15:10]) < 60) && (int'(t[9:0]) < 1000);
  endfunction

  function automatic vec_t mk(logic st, logic sp, logic cl, logic dr, logic ld, logic [26:0] lt,
                              logic [26:0] et, logic er, logic ems, logic esec, logic ez, logic eerr);
    vec_t v;
    v.st = st; v.sp = sp; v.cl = cl; v.dr = dr; v.ld = ld; v.lt = lt;
    v.et = et; v.er = er; v.ems = ems; v.esec = esec; v.ez = ez; v.eerr = eerr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [26:0] act, input logic [26:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pre = 0; m_total = 0; m_lap = 0;
    e_ms = 0; e_sec = 0; e_zero = 0; e_err = 0;
  endtask

  task automatic advance();
    if (!dir) begin
      m_total = (m_total + 1) % FULL;
      e_ms    = 1;
      e_sec   = (m_total % 1000 == 0);
    end else if (m_total == 0) begin
      m_mode = 2; e_zero = 1;
    end else begin
      e_sec = (m_total % 1000 == 0);
      m_total--;
      e_ms = 1;
      if (m_total == 0) begin
        e_zero = 1; m_mode = 2;
      end
    end
  endtask

  task automatic model_step();
    int old;
    old = m_total;
    e_ms = 0; e_sec = 0; e_zero = 0; e_err = 0;
    if (lap) m_lap = old;
    if (clear) begin
      m_total = 0; m_pre = 0;
      if (m_mode == 2) m_mode = 0;
    end else if (load && fields_ok(load_time)) begin
      m_total = to_ms(load_time); m_pre = 0;
      if (m_mode == 2) m_mode = 0;
    end else begin
      e_err = load;
      if (m_mode == 0) begin
        if (!load && !stop && start && !(dir && m_total == 0)) m_mode = 1;
      end else if (m_mode == 1) begin
        if (!load && stop) m_mode = 0;
        else begin
          m_pre++;
          if (m_pre == DIV) begin
            m_pre = 0;
            advance();
          end
        end
      end
    end
  endtask

  task automatic clr_in();
    start = 0; stop = 0; clear = 0; load = 0; lap = 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, ".time"}, cur_time, '0);
    chk({tag, ".lap"}, lap_time, '0);
    chk({tag, ".running"}, running, 0);
    chk({tag, ".ms_tick"}, ms_tick, 0);
    chk({tag, ".sec_tick"}, sec_tick, 0);
    chk({tag, ".zero"}, zero, 0);
    chk({tag, ".load_err"}, load_err, 0);
  endtask

  task automatic do_reset();
    clr_in();
    reset = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_zero_outputs("reset");
    reset = 1;
  endtask

  task automatic check_model(input int n);
    chk($sformatf("rnd%0d.time", n), cur_time, from_ms(m_total));
    chk($sformatf("rnd%0d.lap", n), lap_time, from_ms(m_lap));
    chk($sformatf("rnd%0d.running", n), running, (m_mode == 1));
    chk($sformatf("rnd%0d.ms_tick", n), ms_tick, e_ms);
    chk($sformatf("rnd%0d.sec_tick", n), sec_tick, e_sec);
    chk($sformatf("rnd%0d.zero", n), zero, e_zero);
    chk($sformatf("rnd%0d.load_err", n), load_err, e_err);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_ms, n_sec;
    reset = 0; dir = 0; load_time = '0;
    clr_in();

    //            st sp cl dr ld load_time            exp_time            run ms sec zr err
    vt[0]  = mk(1, 0, 0, 0, 0, '0,                 '0,                 1, 0, 0, 0, 0);
    vt[1]  = mk(0, 0, 0, 0, 0, '0,                 '0,                 1, 0, 0, 0, 0);
    vt[2]  = mk(0, 0, 0, 0, 0, '0,                 '0,                 1, 0, 0, 0, 0);
    vt[3]  = mk(0, 0, 0, 0, 0, '0,                 '0,                 1, 0, 0, 0, 0);
    vt[4]  = mk(0, 0, 0, 0, 0, '0,                 pk(0,0,0,1),        1, 1, 0, 0, 0);
    vt[5]  = mk(0, 0, 0, 0, 0, '0,                 pk(0,0,0,1),        1, 0, 0, 0, 0);
    vt[6]  = mk(0, 0, 0, 0, 1, pk(0,0,60,0),       pk(0,0,0,1),        1, 0, 0, 0, 1);
    vt[7]  = mk(0, 0, 1, 0, 1, pk(1,2,3,4),        '0,                 1, 0, 0, 0, 0);
    vt[8]  = mk(1, 1, 0, 0, 0, '0,                 '0,                 0, 0, 0, 0, 0);
    vt[9]  = mk(0, 0, 0, 0, 1, pk(1,2,3,4),        pk(1,2,3,4),        0, 0, 0, 0, 0);
    vt[10] = mk(0, 0, 0, 0, 1, pk(24,0,0,0),       pk(1,2,3,4),        0, 0, 0, 0, 1);
    vt[11] = mk(0, 0, 0, 0, 1, pk(0,60,0,0),       pk(1,2,3,4),        0, 0, 0, 0, 1);
    vt[12] = mk(0, 0, 0, 0, 1, pk(0,0,0,1000),     pk(1,2,3,4),        0, 0, 0, 0, 1);
    vt[13] = mk(0, 0, 0, 0, 1, pk(23,59,59,999),   pk(23,59,59,999),   0, 0, 0, 0, 0);
    vt[14] = mk(0, 0, 1, 0, 0, '0,                 '0,                 0, 0, 0, 0, 0);
    vt[15] = mk(1, 0, 0, 1, 0, '0,                 '0,                 0, 0, 0, 0, 0);

    do_reset();
    for (int i = 0; i < NV; i++) begin
      start = vt[i].st; stop = vt[i].sp; clear = vt[i].cl; dir = vt[i].dr;
      load = vt[i].ld; load_time = vt[i].lt;
      tick();
      chk($sformatf("v%0d.time", i), cur_time, vt[i].et);
      chk($sformatf("v%0d.running", i), running, vt[i].er);
      chk($sformatf("v%0d.ms_tick", i), ms_tick, vt[i].ems);
      chk($sformatf("v%0d.sec_tick", i), sec_tick, vt[i].esec);
      chk($sformatf("v%0d.zero", i), zero, vt[i].ez);
      chk($sformatf("v%0d.load_err", i), load_err, vt[i].eerr);
    end
    clr_in();
    dir = 0;

    // One second of up-counting: 1000 ms ticks, exactly one sec tick.
    do_reset();
    start = 1; tick(); clr_in();
    n_ms = 0; n_sec = 0;
    for (int i = 0; i < 4000; i++) begin
      tick();
      n_ms  += int'(ms_tick);
      n_sec += int'(sec_tick);
    end
    chk("sec.time", cur_time, pk(0,0,1,0));
    chk("sec.ms_count", 27'(n_ms), 27'd1000);
    chk("sec.sec_count", 27'(n_sec), 27'd1);

    // Full-range wrap keeps running.
    do_reset();
    load = 1; load_time = pk(23,59,59,999); tick(); clr_in();
    start = 1; tick(); clr_in();
    repeat (4) tick();
    chk("wrap.time", cur_time, '0);
    chk("wrap.sec_tick", sec_tick, 1);
    chk("wrap.ms_tick", ms_tick, 1);
    chk("wrap.running", running, 1);

    // Down count to zero, expiry, ignored start/stop, clear back to stopped.
    do_reset();
    dir = 1; load = 1; load_time = pk(0,0,0,2); tick(); clr_in();
    start = 1; tick(); clr_in();
    repeat (4) tick();
    chk("down.time1", cur_time, pk(0,0,0,1));
    repeat (4) tick();
    chk("down.time0", cur_time, '0);
    chk("down.zero", zero, 1);
    chk("down.ms_tick", ms_tick, 1);
    chk("down.running", running, 0);
    dir = 0; start = 1; tick(); clr_in();
    chk("exp.start_ignored", running, 0);
    chk("exp.zero_once", zero, 0);
    repeat (5) tick();
    chk("exp.time_held", cur_time, '0);
    clear = 1; tick(); clr_in();
    chk("exp.clear_running", running, 0);
    start = 1; tick(); clr_in();
    chk("exp.restart", running, 1);

    // Stop holds the partial millisecond; resume completes it two cycles later.
    do_reset();
    start = 1; tick(); clr_in();
    repeat (2) tick();
    stop = 1; tick(); clr_in();
    chk("pause.running", running, 0);
    n_ms = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_ms += int'(ms_tick);
    end
    chk("pause.no_ticks", 27'(n_ms), '0);
    start = 1; tick(); clr_in();
    chk("resume.running", running, 1);
    tick();
    chk("resume.early", ms_tick, 0);
    tick();
    chk("resume.ms_tick", ms_tick, 1);
    chk("resume.time", cur_time, pk(0,0,0,1));
    start = 1; stop = 1; tick(); clr_in();
    chk("stop_wins", running, 0);

    // Lap on the update edge captures the pre-update time.
    do_reset();
    load = 1; load_time = pk(0,0,0,3); tick(); clr_in();
    start = 1; tick(); clr_in();
    repeat (3) tick();
    lap = 1; tick(); clr_in();
    chk("lap.time", cur_time, pk(0,0,0,4));
    chk("lap.lap_time", lap_time, pk(0,0,0,3));
    chk("lap.ms_tick", ms_tick, 1);

    // Asynchronous reset mid-run, then no counting until start.
    repeat (2) tick();
    #2;
    reset = 0;
    #1;
    check_zero_outputs("async");
    model_reset();
    @(posedge clock);
    #1;
    reset = 1;
    repeat (6) tick();
    chk("post_reset.running", running, 0);
    chk("post_reset.time", cur_time, '0);

    // Random stimulus against the millisecond model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      start = ($urandom_range(0, 99) < 12);
      stop  = ($urandom_range(0, 99) < 6);
      clear = ($urandom_range(0, 99) < 2);
      load  = ($urandom_range(0, 99) < 4);
      lap   = ($urandom_range(0, 99) < 8);
      if ($urandom_range(0, 99) < 4) dir = ~dir;
      case ($urandom_range(0, 3))
        0:       load_time = 27'($urandom);
        1:       load_time = from_ms(int'($urandom_range(0, 30)));
        2:       load_time = from_ms(FULL - 1 - int'($urandom_range(0, 30)));
        default: load_time = pk(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)),
                                int'($urandom_range(0, 59)), int'($urandom_range(0, 999)));
      endcase
      tick();
      check_model(n);
    end
    clr_in();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
